// File: rtl/hca24_stream_accumulator_if.sv
// Stream bundle for the 24-bit accumulator: operand valid/ready in, result valid/ready out.
interface hca24_stream_accumulator_if #(
    parameter int CNT_W  = 8,
    parameter int DATA_W = 24
);
    logic              start;
    logic [CNT_W-1:0]  len;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_sum;
    logic              out_ovf;
    logic              busy;

    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, busy
    );
    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, busy
    );
endinterface

// File: rtl/hca24_stream_accumulator.sv
// Streamed burst accumulator around a 24-bit Han-Carlson adder.
// Optional macro HCA_ACC_SATURATE_EN clamps the sum at full scale instead of wrapping.
module UBHCA_23_0_23_0 (
    input  logic [23:0] X,
    input  logic [23:0] Y,
    output logic [24:0] S
);
    // Level 0: bit g/p; 1: odd bits pair up; 2..5: odd-only Kogge-Stone; 6: even fix-up.
    logic [6:0][23:0] w_g, w_p;
    logic             w_unused_p;

    assign w_g[0] = X & Y;
    assign w_p[0] = X ^ Y;

    for (genvar lv = 1; lv <= 6; lv++) begin : g_lvl
        for (genvar i = 0; i < 24; i++) begin : g_bit
            localparam int D   = (lv == 1 || lv == 6) ? 1 : (1 << (lv - 1));
            localparam bit ACT = (lv == 6) ? ((i % 2 == 0) && (i >= 2))
                                           : ((i % 2 == 1) && (i >= D));
            if (ACT) begin : g_op
                assign w_g[lv][i] = w_g[lv-1][i] | (w_p[lv-1][i] & w_g[lv-1][i-D]);
                assign w_p[lv][i] = w_p[lv-1][i] & w_p[lv-1][i-D];
            end else begin : g_pass
                assign w_g[lv][i] = w_g[lv-1][i];
                assign w_p[lv][i] = w_p[lv-1][i];
            end
        end
    end

    assign S[23:0]    = w_p[0] ^ {w_g[6][22:0], 1'b0};
    assign S[24]      = w_g[6][23];
    assign w_unused_p = ^w_p[6];
endmodule

module hca24_stream_accumulator #(
    parameter int CNT_W  = 8,
    parameter int DATA_W = 24
) (
    input logic                        clk,
    input logic                        rst_n,
    hca24_stream_accumulator_if.slave  sif
);
    if (DATA_W != 24) begin : g_bad_cfg
        $error("hca24_stream_accumulator: DATA_W must be 24");
    end

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [23:0]        r_acc, r_out_sum, w_acc_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf, r_out_ovf, w_ovf_nxt;
    logic               w_in_ready, w_out_valid, w_busy, w_accept, w_last;
    logic [24:0]        w_s;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    UBHCA_23_0_23_0 u_add (.X(r_acc), .Y(sif.in_data), .S(w_s));

    assign w_accept  = w_in_ready & sif.in_valid;
    assign w_last    = (r_cnt == CNT_ONE);
    assign w_ovf_nxt = r_ovf | w_s[24];
`ifdef HCA_ACC_SATURATE_EN
    // Once a burst has overflowed it stays pinned at full scale.
    assign w_acc_nxt = w_ovf_nxt ? 24'hFFFFFF : w_s[23:0];
`else
    assign w_acc_nxt = w_s[23:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            IDLE: begin
                if (sif.start) w_state_nxt = (sif.len == '0) ? DONE : ACC;
            end
            ACC: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
                if (sif.in_valid && w_last) w_state_nxt = DONE;
            end
            DONE: begin
                w_out_valid = 1'b1;
                w_busy      = 1'b1;
                if (sif.out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Result registers are loaded only when entering DONE so they survive the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_out_sum <= '0;
            r_out_ovf <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (sif.start) begin
                    r_acc <= '0;
                    r_ovf <= 1'b0;
                    r_cnt <= sif.len;
                    if (sif.len == '0) begin
                        r_out_sum <= '0;
                        r_out_ovf <= 1'b0;
                    end
                end
                ACC: if (w_accept) begin
                    r_acc <= w_acc_nxt;
                    r_ovf <= w_ovf_nxt;
                    r_cnt <= r_cnt - CNT_ONE;
                    if (w_last) begin
                        r_out_sum <= w_acc_nxt;
                        r_out_ovf <= w_ovf_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sif.in_ready  = w_in_ready;
    assign sif.out_valid = w_out_valid;
    assign sif.out_sum   = r_out_sum;
    assign sif.out_ovf   = r_out_ovf;
    assign sif.busy      = w_busy;
endmodule

// File: tb/tb_hca24_stream_accumulator.sv
// Directed bench for hca24_stream_accumulator; expectations follow HCA_ACC_SATURATE_EN when defined.
module tb_hca24_stream_accumulator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    hca24_stream_accumulator_if #(.CNT_W(8), .DATA_W(24)) bus ();

    hca24_stream_accumulator #(.CNT_W(8), .DATA_W(24)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sif   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_done(input string tag, input logic [23:0] sum, input logic ovf);
        chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({tag, "_sum"},   {8'd0, bus.out_sum},    {8'd0, sum});
        chk({tag, "_ovf"},   {31'd0, bus.out_ovf},   {31'd0, ovf});
        chk({tag, "_rdy"},   {31'd0, bus.in_ready},  32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rdy"},  {31'd0, bus.in_ready},  32'd0);
        chk({tag, "_ov"},   {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_sum"},  {8'd0, bus.out_sum},    32'd0);
        chk({tag, "_ovf"},  {31'd0, bus.out_ovf},   32'd0);
        chk({tag, "_busy"}, {31'd0, bus.busy},      32'd0);
    endtask

    task automatic begin_burst(input logic [7:0] n);
        bus.start = 1'b1;
        bus.len   = n;
        step();
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [23:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic handshake(input string tag);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk({tag, "_drop"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_idle"}, {31'd0, bus.busy},      32'd0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("idle_rdy", {31'd0, bus.in_ready}, 32'd0);

        // Basic burst: 1+2+3
        begin_burst(8'd3);
        chk("basic_busy", {31'd0, bus.busy},     32'd1);
        chk("basic_rdy",  {31'd0, bus.in_ready}, 32'd1);
        send(24'h000001);
        send(24'h000002);
        chk("basic_mid_ov", {31'd0, bus.out_valid}, 32'd0);
        send(24'h000003);
        chk_done("basic", 24'h000006, 1'b0);
        chk("basic_busy2", {31'd0, bus.busy}, 32'd1);
        handshake("basic");
        chk("basic_hold", {8'd0, bus.out_sum}, 32'h000006);

        // Wrap or saturate
        begin_burst(8'd2);
        send(24'hFFFFFF);
        send(24'h000002);
`ifdef HCA_ACC_SATURATE_EN
        chk_done("wrap", 24'hFFFFFF, 1'b1);
`else
        chk_done("wrap", 24'h000001, 1'b1);
`endif
        handshake("wrap");

        // Zero-length burst
        begin_burst(8'd0);
        chk_done("zero", 24'h000000, 1'b0);
        handshake("zero");

        // Bubbles on input, then output backpressure with a stray start and in_valid
        begin_burst(8'd4);
        bus.in_data = 24'h100000;
        bus.in_valid = 1'b1; step();
        bus.in_valid = 1'b0; step();
        bus.in_valid = 1'b1; step();
        bus.in_valid = 1'b0; step();
        chk("bub_rdy", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1; step();
        chk("bub_notyet", {31'd0, bus.out_valid}, 32'd0);
        step();
        chk_done("bub", 24'h400000, 1'b0);
        bus.start = 1'b1;
        bus.len   = 8'd3;
        for (int k = 0; k < 5; k++) begin
            step();
            bus.start = 1'b0;
            chk_done("bp", 24'h400000, 1'b0);
        end
        bus.in_valid = 1'b0;
        handshake("bp");

        // Asynchronous reset mid-burst
        begin_burst(8'd5);
        send(24'h000010);
        send(24'h000010);
        #3 rst_n = 1'b0;
        #1 chk_zero("arst");
        bus.start = 1'b1;
        bus.len   = 8'd1;
        rst_n     = 1'b1;
        step();
        bus.start = 1'b0;
        chk("arst_acc", {31'd0, bus.in_ready}, 32'd1);
        send(24'h000007);
        chk_done("arst_b", 24'h000007, 1'b0);
        handshake("arst_b");

        // Back-to-back bursts; overflow cleared by the following start
        begin_burst(8'd2);
        send(24'h000005);
        send(24'h000005);
        chk_done("b2b1", 24'h00000A, 1'b0);
        handshake("b2b1");
        begin_burst(8'd2);
        send(24'h800000);
        send(24'h800000);
`ifdef HCA_ACC_SATURATE_EN
        chk_done("b2b2", 24'hFFFFFF, 1'b1);
`else
        chk_done("b2b2", 24'h000000, 1'b1);
`endif
        handshake("b2b2");
        begin_burst(8'd1);
        send(24'h000001);
        chk_done("b2b3", 24'h000001, 1'b0);
        handshake("b2b3");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
